keypad_matrix_scanner: RTL
==========================

Name: keypad_matrix_scanner

Overview:
Scans a passive key matrix of N_COLS columns by N_ROWS rows (5x7 by default, the same geometry as the LED matrix) for attack coordinate entry.
- Drives one column at a time and samples the row lines.
- Debounces press and release.
- Emits a one-cycle key_valid pulse with a 3-bit column/row coordinate.
- The coordinate has the same format as columns_attack/rows_attack, so the main controller can take it in place of the switch inputs.
- Runs on the divided scan clock domain, qualified by a tick enable.

Parameters:
N_COLS, 5, number of driven column lines (1..8)
N_ROWS, 7, number of sensed row lines (1..8)
SETTLE_TICKS, 2, scan ticks a column is driven before its rows are sampled (>=1)
DEBOUNCE_SCANS, 4, consecutive identical samples required to accept a press or a release (>=1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
scan_en  input  1  scan tick; one clk cycle wide; all counters advance only when it is high
row_in  input  N_ROWS  raw row lines, active-low (pulled up), asynchronous to clk
col_drive  output  N_COLS  column strobes, active-low one-hot
key_valid  output  1  one-cycle pulse when a press is accepted
key_col  output  3  column index of the last accepted key (0..N_COLS-1)
key_row  output  3  row index of the last accepted key (0..N_ROWS-1)
key_held  output  1  high from acceptance until the release is accepted

Behaviour:
- Reset (asynchronous assert, synchronous deassert inside the block), as values after reset:
  - state = SCAN, column index = 0, col_drive = all ones except bit0 = 0.
  - key_valid = 0, key_col = 0, key_row = 0, key_held = 0.
  - All counters = 0, synchronizer flops = all ones.
- row_in passes through a 2-flop synchronizer and is inverted to active-high "hit" bits. All decisions use the synchronized value.
- SCAN:
  - Drive the current column. Each scan_en increments settle_cnt.
  - On the scan_en where settle_cnt == SETTLE_TICKS-1, sample. If no hit: advance the column (N_COLS-1 wraps to 0) and clear settle_cnt.
  - If any hit: latch cand_row = lowest-index hit row, set deb_cnt = 1, go to CONFIRM. The column is held.
- CONFIRM: sample on every scan_en.
  - Same column and cand_row still hit: deb_cnt++.
  - cand_row not hit: return to SCAN, advance to the next column, settle_cnt = 0.
  - When deb_cnt reaches DEBOUNCE_SCANS (immediately if DEBOUNCE_SCANS = 1): the next clk cycle loads key_col/key_row, pulses key_valid for exactly one cycle, sets key_held = 1, and enters HELD.
- HELD: column stays driven; sample on every scan_en.
  - cand_row not hit: rel_cnt++. cand_row hit: rel_cnt = 0.
  - When rel_cnt reaches DEBOUNCE_SCANS: key_held = 0, go to SCAN at the next column.
  - Other keys pressed meanwhile are ignored (no rollover).
- Simultaneous hits in one column: lowest row index wins. Ghost keys in other columns are not detected while the column is held.
- key_col and key_row hold their last accepted value until the next acceptance.
- scan_en low: the FSM and counters freeze; outputs hold.
- reset_n asserted in any state (including mid-CONFIRM or HELD): immediate return to the reset values. No key_valid is produced for a partially debounced press.
- Width rule: indices are zero-extended to 3 bits. Counters are sized $clog2(max+1).

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, CONFIRM, HELD}
  - KEY_IDX_W = 3
  - Helper function for lowest-set-bit index.
- Sub-module keypad_row_sync: parameterised-width 2-flop synchronizer with async active-low reset to all ones.
- The FSM, counters and column ring stay in the top module.

Test Plan:
1. Reset, no keys, SETTLE_TICKS=2 -> col_drive cycles 11110, 11101, 11011, 10111, 01111, 11110, changing every 2 scan_en; key_valid never pulses.
2. Hold row 3 low while column 2 is driven, stable for >=4 samples -> exactly one key_valid pulse; key_col=2, key_row=3, key_held=1.
3. Bounce: row 3 low for 2 samples, high for 1, during column 2 -> no key_valid; scanning resumes at column 3.
4. Rows 1 and 5 both low in column 0 -> key_row=1. Release with 3 high samples then 1 low -> key_held stays 1. Then 4 consecutive high samples -> key_held=0 and scanning resumes at column 1.
5. Keep scan_en low for 100 cycles mid-CONFIRM -> no state change. Assert reset_n=0 mid-HELD -> all outputs return to reset values asynchronously, col_drive=11110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  localparam int KEY_IDX_W = 3;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    HELD
  } state_t;

  // Index of the lowest set bit; returns 0 when no bit is set.
  function automatic logic [KEY_IDX_W-1:0] lowest_set_idx(input logic [7:0] bits);
    lowest_set_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) lowest_set_idx = KEY_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row lines. Resets to all ones,
// which matches idle pulled-up rows, so no phantom hit appears after reset.
module keypad_row_sync #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // Two register stages to settle metastability before the FSM sees the rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= '1;
      sync_out <= '1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-strobed key matrix scanner with press/release debouncing. Emits a
// one-cycle key_valid pulse with the column/row coordinate of an accepted key.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int N_COLS         = 5,
  parameter int N_ROWS         = 7,
  parameter int SETTLE_TICKS   = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 scan_en,
  input  logic [N_ROWS-1:0]    row_in,
  output logic [N_COLS-1:0]    col_drive,
  output logic                 key_valid,
  output logic [KEY_IDX_W-1:0] key_col,
  output logic [KEY_IDX_W-1:0] key_row,
  output logic                 key_held
);

  localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);
  localparam int DEB_W    = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);
  localparam logic [DEB_W-1:0]     DEB_TARGET  = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [KEY_IDX_W-1:0] LAST_COL    = KEY_IDX_W'(N_COLS - 1);

  logic                 rst_meta_n;
  logic                 rst_n;
  logic [N_ROWS-1:0]    row_sync;
  logic [7:0]           hit_ext;
  logic                 any_hit;
  logic                 cand_hit;
  logic [KEY_IDX_W-1:0] next_col;

  state_t               state;
  logic [KEY_IDX_W-1:0] col_idx;
  logic [KEY_IDX_W-1:0] cand_row;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [DEB_W-1:0]     deb_cnt;
  logic [DEB_W-1:0]     rel_cnt;

  // Active-low strobe pattern with only the selected column pulled low.
  function automatic logic [N_COLS-1:0] col_mask(input logic [KEY_IDX_W-1:0] idx);
    logic [7:0] m;
    m = ~(8'd1 << idx);
    return m[N_COLS-1:0];
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_n <= 1'b0;
      rst_n      <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_n      <= rst_meta_n;
    end
  end

  keypad_row_sync #(
    .WIDTH (N_ROWS)
  ) u_row_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (row_in),
    .sync_out (row_sync)
  );

  // Active-high hits zero-extended to the 8-bit helper width.
  always_comb begin
    hit_ext               = '0;
    hit_ext[N_ROWS-1:0]   = ~row_sync;
    any_hit               = |hit_ext;
    cand_hit              = hit_ext[cand_row];
    next_col              = (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
  end

  // Scan / confirm / held state machine with its counters and the column ring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      col_idx    <= '0;
      col_drive  <= col_mask('0);
      cand_row   <= '0;
      settle_cnt <= '0;
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      key_valid  <= 1'b0;
      key_col    <= '0;
      key_row    <= '0;
      key_held   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_en) begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              if (any_hit) begin
                cand_row <= lowest_set_idx(hit_ext);
                deb_cnt  <= DEB_W'(1);
                state    <= CONFIRM;
              end else begin
                col_idx   <= next_col;
                col_drive <= col_mask(next_col);
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end

        CONFIRM: begin
          if (deb_cnt >= DEB_TARGET) begin
            key_valid <= 1'b1;
            key_col   <= col_idx;
            key_row   <= cand_row;
            key_held  <= 1'b1;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            state     <= HELD;
          end else if (scan_en) begin
            if (cand_hit) begin
              deb_cnt <= deb_cnt + 1'b1;
            end else begin
              deb_cnt    <= '0;
              settle_cnt <= '0;
              col_idx    <= next_col;
              col_drive  <= col_mask(next_col);
              state      <= SCAN;
            end
          end
        end

        HELD: begin
          if (rel_cnt >= DEB_TARGET) begin
            key_held   <= 1'b0;
            rel_cnt    <= '0;
            settle_cnt <= '0;
            col_idx    <= next_col;
            col_drive  <= col_mask(next_col);
            state      <= SCAN;
          end else if (scan_en) begin
            if (cand_hit) rel_cnt <= '0;
            else          rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule
